// File: rtl/dxl_pkg.sv
// Shared Dynamixel protocol 2.0 constants, parser state encoding and the
// byte-wise CRC-16 step used by the receive and transmit paths.
package dxl_pkg;

  localparam logic [7:0]  DXL_HDR_FF      = 8'hFF;
  localparam logic [7:0]  DXL_HDR_FD      = 8'hFD;
  localparam logic [7:0]  DXL_HDR_RSV     = 8'h00;
  localparam logic [7:0]  DXL_INST_PING   = 8'h01;
  localparam logic [7:0]  DXL_INST_READ   = 8'h02;
  localparam logic [7:0]  DXL_INST_WRITE  = 8'h03;
  localparam logic [7:0]  DXL_INST_STATUS = 8'h55;
  localparam logic [15:0] CRC_POLY        = 16'h8005;

  typedef enum logic [3:0] {
    ST_IDLE, ST_H2, ST_H3, ST_RSV, ST_ID, ST_LEN_L, ST_LEN_H,
    ST_INST, ST_ERR, ST_PARAM, ST_CRC_L, ST_CRC_H
  } dxl_state_e;

  function automatic logic [15:0] crc16_update(input logic [15:0] crc,
                                               input logic [7:0]  data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/dxl_crc16.sv
// Single-cycle CRC-16 (poly 0x8005, init 0) byte accumulator. When clear and
// en are both high the byte starts a fresh CRC.
module dxl_crc16
  import dxl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d, base;

  always_comb begin
    base  = clear ? 16'h0000 : crc_q;
    crc_d = crc_q;
    if (en)         crc_d = crc16_update(base, data);
    else if (clear) crc_d = 16'h0000;
  end

  always_ff @(posedge clock) begin
    if (reset) crc_q <= 16'h0000;
    else       crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/dxl_status_parser.sv
// Byte-stream parser for Dynamixel 2.0 status packets: header sync, LEN/INST
// validation, param destuffing, CRC check and an inter-byte timeout.
module dxl_status_parser
  import dxl_pkg::*;
#(
  parameter int MAX_PARAMS     = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_LEN        = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        status_valid,
  output logic [7:0]  status_id,
  output logic [7:0]  status_error,
  output logic [31:0] status_param,
  output logic [2:0]  status_param_count,
  output logic        param_overflow,
  output logic        crc_error,
  output logic        frame_error,
  output logic        busy
);

  localparam int          TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0]  MAXP = 3'(MAX_PARAMS);

  dxl_state_e  state_q, state_d;
  logic [TW-1:0] idle_cnt_q;
  logic [7:0]  id_q, err_q, len_lo_q, crc_lo_q;
  logic [15:0] rem_q, len_w, crc_val;
  logic [23:0] hist_q;
  logic [31:0] param_q;
  logic [2:0]  pcnt_q;
  logic        ovf_q;
  logic        sv_q, ce_q, fe_q, ovf_out_q;
  logic [7:0]  sid_q, serr_q;
  logic [31:0] sparam_q;
  logic [2:0]  scnt_q;
  logic        timeout, take, len_bad, inst_bad, stuffed, crc_ok;
  logic        crc_clear, crc_en, frame_pulse, accept, crc_fail;

  assign timeout  = (state_q != ST_IDLE) && (idle_cnt_q == TW'(TIMEOUT_CYCLES));
  assign take     = rx_valid && !timeout;
  assign len_w    = {rx_data, len_lo_q};
  assign len_bad  = (len_w < 16'd4) || (len_w > 16'(MAX_LEN));
  assign inst_bad = (rx_data != DXL_INST_STATUS);
  assign stuffed  = (rx_data == DXL_HDR_FD) && (hist_q == 24'hFFFFFD);
  assign crc_ok   = ({rx_data, crc_lo_q} == crc_val);

  dxl_crc16 u_crc (
    .clock (clock),
    .reset (reset),
    .clear (crc_clear),
    .en    (crc_en),
    .data  (rx_data),
    .crc   (crc_val)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = ST_IDLE;
    end else if (rx_valid) begin
      case (state_q)
        ST_IDLE:  if (rx_data == DXL_HDR_FF) state_d = ST_H2;
        ST_H2:    state_d = (rx_data == DXL_HDR_FF) ? ST_H3 : ST_IDLE;
        ST_H3:    if (rx_data == DXL_HDR_FD)      state_d = ST_RSV;
                  else if (rx_data != DXL_HDR_FF) state_d = ST_IDLE;
        ST_RSV:   state_d = (rx_data == DXL_HDR_RSV) ? ST_ID : ST_IDLE;
        ST_ID:    state_d = ST_LEN_L;
        ST_LEN_L: state_d = ST_LEN_H;
        ST_LEN_H: state_d = len_bad ? ST_IDLE : ST_INST;
        ST_INST:  state_d = inst_bad ? ST_IDLE : ST_ERR;
        ST_ERR:   state_d = (rem_q == 16'd0) ? ST_CRC_L : ST_PARAM;
        ST_PARAM: state_d = (rem_q == 16'd1) ? ST_CRC_L : ST_PARAM;
        ST_CRC_L: state_d = ST_CRC_H;
        ST_CRC_H: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Extra FFs while waiting for FD leave the CRC at its FF FF value.
  always_comb begin
    busy        = (state_q != ST_IDLE);
    crc_clear   = (state_q == ST_IDLE);
    crc_en      = take && (state_q != ST_CRC_L) && (state_q != ST_CRC_H) &&
                  !((state_q == ST_H3) && (rx_data == DXL_HDR_FF));
    frame_pulse = timeout ||
                  (take && (((state_q == ST_LEN_H) && len_bad) ||
                            ((state_q == ST_INST) && inst_bad)));
    accept      = take && (state_q == ST_CRC_H) && crc_ok;
    crc_fail    = take && (state_q == ST_CRC_H) && !crc_ok;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idle_cnt_q <= '0;
      id_q <= '0; err_q <= '0; len_lo_q <= '0; crc_lo_q <= '0;
      rem_q <= '0; hist_q <= '0; param_q <= '0; pcnt_q <= '0; ovf_q <= 1'b0;
      sv_q <= 1'b0; ce_q <= 1'b0; fe_q <= 1'b0;
      sid_q <= '0; serr_q <= '0; sparam_q <= '0; scnt_q <= '0; ovf_out_q <= 1'b0;
    end else begin
      sv_q <= accept;
      ce_q <= crc_fail;
      fe_q <= frame_pulse;
      if ((state_q == ST_IDLE) || rx_valid) idle_cnt_q <= '0;
      else if (!timeout)                    idle_cnt_q <= idle_cnt_q + TW'(1);
      if (take) begin
        case (state_q)
          ST_ID:    id_q     <= rx_data;
          ST_LEN_L: len_lo_q <= rx_data;
          ST_LEN_H: rem_q    <= len_w - 16'd4;
          ST_ERR: begin
            err_q   <= rx_data;
            param_q <= '0;
            pcnt_q  <= '0;
            ovf_q   <= 1'b0;
            hist_q  <= '0;
          end
          ST_PARAM: begin
            rem_q  <= rem_q - 16'd1;
            hist_q <= {hist_q[15:0], rx_data};
            if (!stuffed) begin
              if (pcnt_q < MAXP) begin
                param_q[{pcnt_q[1:0], 3'b000} +: 8] <= rx_data;
                pcnt_q <= pcnt_q + 3'd1;
              end else begin
                ovf_q <= 1'b1;
              end
            end
          end
          ST_CRC_L: crc_lo_q <= rx_data;
          default: ;
        endcase
      end
      if (accept) begin
        sid_q     <= id_q;
        serr_q    <= err_q;
        sparam_q  <= param_q;
        scnt_q    <= pcnt_q;
        ovf_out_q <= ovf_q;
      end
    end
  end

  assign status_valid       = sv_q;
  assign crc_error          = ce_q;
  assign frame_error        = fe_q;
  assign status_id          = sid_q;
  assign status_error       = serr_q;
  assign status_param       = sparam_q;
  assign status_param_count = scnt_q;
  assign param_overflow     = ovf_out_q;

endmodule

// File: tb/tb_dxl_status_parser.sv
// Directed and randomized bench for dxl_status_parser with a packet-level
// reference model (bit-serial CRC, sliding-window destuff).
module tb_dxl_status_parser;

  typedef logic [7:0] bq_t[$];
  localparam int TMO = 1000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        status_valid, param_overflow, crc_error, frame_error, busy;
  logic [7:0]  status_id, status_error;
  logic [31:0] status_param;
  logic [2:0]  status_param_count;

  int n_pass = 0, n_total = 0;
  int sv_seen = 0, ce_seen = 0, fe_seen = 0;
  int sv0 = 0, ce0 = 0, fe0 = 0;
  logic [7:0]  exp_id = 0, exp_err = 0;
  logic [31:0] exp_param = 0;
  logic [2:0]  exp_cnt = 0;
  logic        exp_ovf = 0;

  dxl_status_parser #(.MAX_PARAMS(4), .TIMEOUT_CYCLES(TMO), .MAX_LEN(16)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .status_valid(status_valid), .status_id(status_id), .status_error(status_error),
    .status_param(status_param), .status_param_count(status_param_count),
    .param_overflow(param_overflow), .crc_error(crc_error),
    .frame_error(frame_error), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (status_valid) sv_seen++;
    if (crc_error)    ce_seen++;
    if (frame_error)  fe_seen++;
  endtask

  task automatic snap();
    sv0 = sv_seen; ce0 = ce_seen; fe0 = fe_seen;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input bq_t q);
    foreach (q[i]) send_byte(q[i]);
  endtask

  // Polynomial long division one message bit at a time.
  function automatic logic [15:0] ref_crc(input bq_t b);
    logic [15:0] c;
    logic fb;
    c = 16'h0000;
    foreach (b[i]) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ b[i][k];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    return c;
  endfunction

  function automatic bq_t destuff(input bq_t raw);
    bq_t o;
    foreach (raw[i]) begin
      if (i >= 3 && raw[i] == 8'hFD && raw[i-3] == 8'hFF &&
          raw[i-2] == 8'hFF && raw[i-1] == 8'hFD) continue;
      o.push_back(raw[i]);
    end
    return o;
  endfunction

  task automatic check_result(input string tag, input bit good);
    chk({tag, "_sv_cnt"}, sv_seen - sv0, good ? 1 : 0);
    chk({tag, "_ce_cnt"}, ce_seen - ce0, good ? 0 : 1);
    chk({tag, "_fe_cnt"}, fe_seen - fe0, 0);
    chk({tag, "_sv_lat"}, status_valid, good);
    chk({tag, "_ce_lat"}, crc_error, !good);
    chk({tag, "_id"},     status_id, exp_id);
    chk({tag, "_err"},    status_error, exp_err);
    chk({tag, "_param"},  status_param, exp_param);
    chk({tag, "_cnt"},    status_param_count, exp_cnt);
    chk({tag, "_ovf"},    param_overflow, exp_ovf);
    chk({tag, "_busy"},   busy, 0);
  endtask

  task automatic run_pkt(input string tag, input logic [7:0] id, input logic [7:0] err,
                         input bq_t raw, input bit corrupt);
    bq_t p, d;
    logic [15:0] len, crc;
    len = 16'(raw.size() + 4);
    p = '{8'hFF, 8'hFF, 8'hFD, 8'h00, id, len[7:0], len[15:8], 8'h55, err};
    foreach (raw[i]) p.push_back(raw[i]);
    crc = ref_crc(p);
    if (corrupt) crc = crc ^ 16'($urandom_range(0, 65534) + 1);
    p.push_back(crc[7:0]);
    p.push_back(crc[15:8]);
    if (!corrupt) begin
      d = destuff(raw);
      exp_id = id; exp_err = err; exp_param = '0;
      foreach (d[i]) if (i < 4) exp_param[8*i +: 8] = d[i];
      exp_cnt = (d.size() > 4) ? 3'd4 : 3'(d.size());
      exp_ovf = (d.size() > 4);
    end
    snap();
    send_bytes(p);
    check_result(tag, !corrupt);
  endtask

  task automatic frame_chk(input string tag, input bq_t q);
    snap();
    send_bytes(q);
    chk({tag, "_fe_cnt"}, fe_seen - fe0, 1);
    chk({tag, "_fe_lat"}, frame_error, 1);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_sv_cnt"}, sv_seen - sv0, 0);
  endtask

  task automatic set_ping_exp();
    exp_id = 8'h01; exp_err = 8'h00; exp_param = 32'h00260406; exp_cnt = 3'd3; exp_ovf = 1'b0;
  endtask

  initial begin
    bq_t ping, bad, garb, raw, empty;
    ping = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00, 8'h55, 8'h00,
             8'h06, 8'h04, 8'h26, 8'h65, 8'h5D};

    // Reset with traffic present: reset must win.
    rx_valid = 1'b1; rx_data = 8'hFF;
    repeat (3) tick();
    rx_valid = 1'b0; reset = 1'b0;
    tick();
    chk("rst_sv",    status_valid, 0);
    chk("rst_id",    status_id, 0);
    chk("rst_err",   status_error, 0);
    chk("rst_param", status_param, 0);
    chk("rst_cnt",   status_param_count, 0);
    chk("rst_ovf",   param_overflow, 0);
    chk("rst_ce",    crc_error, 0);
    chk("rst_fe",    frame_error, 0);
    chk("rst_busy",  busy, 0);

    // Spec ping packet.
    set_ping_exp();
    snap();
    foreach (ping[i]) begin
      send_byte(ping[i]);
      if (i == 5) chk("ping_busy_mid", busy, 1);
    end
    check_result("ping", 1'b1);

    bad = ping;
    bad[13] = 8'h5E;
    snap();
    send_bytes(bad);
    check_result("badcrc", 1'b0);

    garb = '{8'h00, 8'hFF, 8'h12, 8'hFF, 8'hFF, 8'hFF, 8'hFD, 8'h00};
    for (int i = 4; i < 14; i++) garb.push_back(ping[i]);
    snap();
    send_bytes(garb);
    check_result("garbage", 1'b1);

    frame_chk("inst03", '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00, 8'h03});
    frame_chk("len256", '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h00, 8'h01});
    frame_chk("len3",   '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h03, 8'h00});
    frame_chk("len17",  '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h11, 8'h00});

    run_pkt("stuff", 8'h05, 8'h00, '{8'hFF, 8'hFF, 8'hFD, 8'hFD, 8'h01}, 1'b0);
    chk("stuff_lit", status_param, 32'h01FDFFFF);
    chk("stuff_cnt_lit", status_param_count, 3'd4);

    run_pkt("seven", 8'h07, 8'h02, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}, 1'b0);
    chk("seven_lit", status_param, 32'h04030201);
    chk("seven_ovf_lit", param_overflow, 1);

    run_pkt("noparam", 8'h09, 8'h80, empty, 1'b0);
    raw.delete();
    for (int i = 0; i < 12; i++) raw.push_back(8'($urandom_range(0, 255)));
    run_pkt("len16", 8'h0A, 8'h11, raw, 1'b0);

    // Inter-byte timeout after the ID byte.
    snap();
    send_bytes('{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01});
    repeat (TMO - 1) tick();
    chk("tmo_early_fe", fe_seen - fe0, 0);
    chk("tmo_early_busy", busy, 1);
    for (int i = 0; i < 4 && fe_seen == fe0; i++) tick();
    chk("tmo_fe", fe_seen - fe0, 1);
    chk("tmo_busy", busy, 0);
    set_ping_exp();
    snap();
    send_bytes(ping);
    check_result("tmo_ping", 1'b1);

    // Back-to-back randomized packets with FF/FD-heavy params.
    for (int n = 0; n < 24; n++) begin
      int np, r;
      raw.delete();
      np = $urandom_range(0, 12);
      for (int i = 0; i < np; i++) begin
        r = $urandom_range(0, 3);
        raw.push_back(r == 0 ? 8'hFF : r == 1 ? 8'hFD : 8'($urandom_range(0, 255)));
      end
      run_pkt($sformatf("rnd%0d", n), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              raw, $urandom_range(0, 3) == 0);
    end

    run_pkt("pre_rst", 8'h33, 8'h44, '{8'hAA, 8'hBB}, 1'b0);
    snap();
    send_bytes('{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07});
    reset = 1'b1; rx_valid = 1'b1; rx_data = 8'h00;
    repeat (2) tick();
    reset = 1'b0; rx_valid = 1'b0;
    tick();
    chk("mid_rst_pulses", (sv_seen - sv0) + (ce_seen - ce0) + (fe_seen - fe0), 0);
    chk("mid_rst_id",    status_id, 0);
    chk("mid_rst_err",   status_error, 0);
    chk("mid_rst_param", status_param, 0);
    chk("mid_rst_cnt",   status_param_count, 0);
    chk("mid_rst_ovf",   param_overflow, 0);
    chk("mid_rst_busy",  busy, 0);
    set_ping_exp();
    snap();
    send_bytes(ping);
    check_result("post_rst_ping", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dxl_status_parser.md
DXL_STATUS_PARSER -- requirements
Module: dxl_status_parser

Interface
REQ-001 SHALL have parameter MAX_PARAMS, default 4, meaning the number of destuffed parameter bytes stored, range 1..4.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning the maximum number of idle clocks allowed between bytes inside a packet.
REQ-003 SHALL have parameter MAX_LEN, default 16, meaning the largest LEN field accepted.
REQ-004 clock  in  1  single clock domain; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 rx_valid  in  1  one-cycle strobe; rx_data is valid when it is high.
REQ-007 rx_data  in  8  received byte from the serial_io UART receiver.
REQ-008 status_valid  out  1  one-cycle pulse; the packet was accepted with a correct CRC.
REQ-009 status_id  out  8  ID of the last accepted packet.
REQ-010 status_error  out  8  ERR byte of the last accepted packet.
REQ-011 status_param  out  32  first destuffed params, little-endian (param0 in bits 7:0); unused bytes are 0.
REQ-012 status_param_count  out  3  number of destuffed params stored, saturating at MAX_PARAMS.
REQ-013 param_overflow  out  1  more params were received than MAX_PARAMS.
REQ-014 crc_error  out  1  one-cycle pulse when a complete packet fails its CRC check.
REQ-015 frame_error  out  1  one-cycle pulse on timeout, bad INST, or bad LEN.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 SHALL use the states IDLE, H2, H3, RSV, ID, LEN_L, LEN_H, INST, ERR, PARAM, CRC_L, CRC_H; each state advances only on rx_valid.
REQ-018 Header is FF FF FD 00:
- IDLE: 0xFF -> H2.
- H2: 0xFF -> H3; any other byte -> IDLE.
- H3: 0xFD -> RSV; 0xFF -> stays in H3; any other byte -> IDLE.
- RSV: 0x00 -> ID; any other byte -> IDLE.
- Header mismatches SHALL raise no error flag.
REQ-019 LEN SHALL be 16-bit little-endian and count INST+ERR+params+CRC in raw (stuffed) bytes; LEN<4 or LEN>MAX_LEN -> frame_error and IDLE.
REQ-020 INST other than 0x55 -> frame_error and IDLE.
REQ-021 Raw parameter byte count = LEN-4; if it is 0, ERR SHALL go directly to CRC_L.
REQ-022 Destuffing: a 0xFD that follows the raw param-field sequence FF FF FD SHALL be dropped from storage, but SHALL still be counted toward LEN and the CRC.
REQ-023 CRC SHALL be CRC-16:
- polynomial 0x8005, init 0x0000, MSB-first, no reflection, no final XOR;
- computed over raw bytes from the first 0xFF through the last param;
- the received CRC is little-endian (CRC_L first).
REQ-024 On the CRC_H byte:
- match -> status_valid pulse the next cycle, with status_id, status_error, status_param, status_param_count and param_overflow updated in that same cycle;
- mismatch -> crc_error pulse, outputs unchanged.
- Either way the FSM SHALL return to IDLE.
REQ-025 Latency SHALL be 1 clock from the CRC_H rx_valid to the status_valid or crc_error pulse.
REQ-026 Status outputs SHALL hold their values until the next accepted packet.
REQ-027 An idle counter SHALL reset on every rx_valid and count while busy; reaching TIMEOUT_CYCLES -> frame_error pulse and IDLE.
REQ-028 A byte arriving in the same cycle as the timeout SHALL be ignored.
REQ-029 Params beyond MAX_PARAMS SHALL set param_overflow; they are discarded but still included in the CRC.
REQ-030 Back-to-back packets with zero gap SHALL be accepted; the FSM SHALL be in IDLE on the cycle after CRC_H.

Reset
REQ-031 Reset SHALL drive the FSM to IDLE and clear the CRC register and idle counter to 0.
REQ-032 Reset SHALL clear all outputs to 0.
REQ-033 Reset SHALL take precedence over rx_valid in the same cycle.
REQ-034 Reset asserted mid-packet SHALL discard the partial packet and produce no pulse.

Structure
REQ-035 A shared package dxl_pkg SHALL hold the DXL_INST_* opcodes, the header byte constants, CRC_POLY = 16'h8005, and the state enumeration.
REQ-036 CRC SHALL be implemented in sub-module dxl_crc16 with ports clock, reset, clear, en, data[7:0], crc[15:0]; it performs a single-cycle byte update and is reusable by the XL320 transmitter.

Verification
REQ-037 Ping status FF FF FD 00 01 07 00 55 00 06 04 26 65 5D -> status_valid, id=0x01, error=0x00, param=0x00260406, count=3, crc_error=0.
REQ-038 Same packet with its last byte changed to 0x5E -> crc_error pulse, no status_valid, outputs keep their previous values.
REQ-039 Leading garbage 00 FF 12 FF FF FF FD 00, followed by the ping body -> accepted exactly as in REQ-037.
REQ-040 Packet with INST=0x03 -> frame_error, busy=0 on the next cycle.
REQ-041 Packet with LEN=0x0100 -> frame_error.
REQ-042 Param field FF FF FD FD 01 with a correct CRC -> stored params FF FF FD 01, count=4.
REQ-043 Seven params 01..07 -> param=0x04030201, param_overflow=1.
REQ-044 Stop after the ID byte and wait TIMEOUT_CYCLES -> frame_error pulse, then the ping is accepted normally.
REQ-045 Reset asserted mid-packet -> no pulse, all outputs 0.
